// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: ALU operation codes, ALUOp classes and the funct3 values the ALU decodes.
package rv32i_pkg;

  typedef logic [2:0] alu_ctl_t;

  localparam alu_ctl_t ALU_ADD = 3'b000;
  localparam alu_ctl_t ALU_SUB = 3'b001;
  localparam alu_ctl_t ALU_AND = 3'b010;
  localparam alu_ctl_t ALU_OR  = 3'b011;
  localparam alu_ctl_t ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-issue request, forwarding sources and issue-to-ALU response bundle for alu_issue_stage.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  logic            InValid;
  logic            InReady;
  logic            Flush;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic [XLEN-1:0] PCIn;
  logic [XLEN-1:0] ImmIn;
  logic [REGW-1:0] Rs1;
  logic [REGW-1:0] Rs2;
  logic [REGW-1:0] RdIn;
  logic            RegWriteIn;
  logic            ALUSrcA;
  logic            ALUSrcB;
  logic [1:0]      ALUOp;
  logic [2:0]      Funct3;
  logic            Funct7b5;
  logic            OpR;
  logic            ExMemRegWrite;
  logic [REGW-1:0] ExMemRd;
  logic [XLEN-1:0] ExMemResult;
  logic            MemWbRegWrite;
  logic [REGW-1:0] MemWbRd;
  logic [XLEN-1:0] MemWbResult;
  logic            OutValid;
  logic            OutReady;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [2:0]      ALUControl;
  logic [REGW-1:0] RdOut;
  logic            RegWriteOut;
  logic [XLEN-1:0] PCOut;
  logic            IllegalOp;

  modport master (
    output InValid, Flush, RD1, RD2, PCIn, ImmIn, Rs1, Rs2, RdIn, RegWriteIn, ALUSrcA, ALUSrcB,
    output ALUOp, Funct3, Funct7b5, OpR, ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite,
    output MemWbRd, MemWbResult, OutReady,
    input  InReady, OutValid, A, B, ALUControl, RdOut, RegWriteOut, PCOut, IllegalOp
  );

  modport slave (
    input  InValid, Flush, RD1, RD2, PCIn, ImmIn, Rs1, Rs2, RdIn, RegWriteIn, ALUSrcA, ALUSrcB,
    input  ALUOp, Funct3, Funct7b5, OpR, ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite,
    input  MemWbRd, MemWbResult, OutReady,
    output InReady, OutValid, A, B, ALUControl, RdOut, RegWriteOut, PCOut, IllegalOp
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct3/funct7 decode into the 3-bit ALU control code plus an illegal flag.
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op_r,
  output alu_ctl_t   o_alu_control,
  output logic       o_illegal
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_illegal     = 1'b0;
    unique case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (i_funct3)
          // Only R-type with bit 30 set is SUB; ADDI never subtracts.
          F3_ADD:  o_alu_control = (i_op_r && i_funct7b5) ? ALU_SUB : ALU_ADD;
          F3_SLT:  o_alu_control = ALU_SLT;
          F3_OR:   o_alu_control = ALU_OR;
          F3_AND:  o_alu_control = ALU_AND;
          default: o_illegal     = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the ALU: forwards, selects operands, decodes ALUControl and holds one op
// behind a valid/ready handshake.
module alu_issue_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_stage_if.slave bus
);

  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  alu_ctl_t        r_alu_control;
  logic [REGW-1:0] r_rd;
  logic            r_reg_write;
  logic [XLEN-1:0] r_pc;
  logic            r_illegal;

  logic            w_in_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  alu_ctl_t        w_alu_control;
  logic            w_illegal;

  assign w_in_ready = !r_valid || bus.OutReady;
  assign w_accept   = bus.InValid && w_in_ready && !bus.Flush;

  // EX/MEM wins over MEM/WB; x0 always reads the register file.
  always_comb begin
    w_fwd1 = bus.RD1;
    if (bus.ExMemRegWrite && (bus.ExMemRd == bus.Rs1) && (bus.Rs1 != '0)) begin
      w_fwd1 = bus.ExMemResult;
    end else if (bus.MemWbRegWrite && (bus.MemWbRd == bus.Rs1) && (bus.Rs1 != '0)) begin
      w_fwd1 = bus.MemWbResult;
    end
  end

  always_comb begin
    w_fwd2 = bus.RD2;
    if (bus.ExMemRegWrite && (bus.ExMemRd == bus.Rs2) && (bus.Rs2 != '0)) begin
      w_fwd2 = bus.ExMemResult;
    end else if (bus.MemWbRegWrite && (bus.MemWbRd == bus.Rs2) && (bus.Rs2 != '0)) begin
      w_fwd2 = bus.MemWbResult;
    end
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (bus.ALUOp),
    .i_funct3      (bus.Funct3),
    .i_funct7b5    (bus.Funct7b5),
    .i_op_r        (bus.OpR),
    .o_alu_control (w_alu_control),
    .o_illegal     (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_alu_control <= ALU_ADD;
      r_rd          <= '0;
      r_reg_write   <= 1'b0;
      r_pc          <= '0;
      r_illegal     <= 1'b0;
    end else if (bus.Flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_accept) begin
      r_valid       <= 1'b1;
      r_a           <= bus.ALUSrcA ? bus.PCIn : w_fwd1;
      r_b           <= bus.ALUSrcB ? bus.ImmIn : w_fwd2;
      r_alu_control <= w_alu_control;
      r_rd          <= bus.RdIn;
      r_reg_write   <= bus.RegWriteIn;
      r_pc          <= bus.PCIn;
      r_illegal     <= w_illegal;
    end else if (r_valid && bus.OutReady) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.InReady     = w_in_ready;
  assign bus.OutValid    = r_valid;
  assign bus.A           = r_a;
  assign bus.B           = r_b;
  assign bus.ALUControl  = r_alu_control;
  assign bus.RdOut       = r_rd;
  assign bus.RegWriteOut = r_reg_write;
  assign bus.PCOut       = r_pc;
  assign bus.IllegalOp   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed test-plan ops plus randomized traffic against a
// behavioural model of forwarding, operand selection and ALU decode.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] rd1, rd2, pc, imm;
    logic [4:0]  rs1, rs2, rdin;
    logic        rw, srca, srcb;
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic        f7, opr, exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
  } op_t;

  typedef struct packed {
    logic [31:0] a, b, pc;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic        rw, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_push = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(32), .REGW(5)) bus ();

  alu_issue_stage #(.XLEN(32), .REGW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_val(input logic [4:0] s, input logic [31:0] rf, input op_t o);
    if (s == 5'd0) return rf;
    if (o.exw && o.exrd == s) return o.exres;
    if (o.wbw && o.wbrd == s) return o.wbres;
    return rf;
  endfunction

  function automatic exp_t model(input op_t o);
    exp_t e;
    e.a   = o.srca ? o.pc : src_val(o.rs1, o.rd1, o);
    e.b   = o.srcb ? o.imm : src_val(o.rs2, o.rd2, o);
    e.pc  = o.pc;
    e.rd  = o.rdin;
    e.rw  = o.rw;
    e.ctl = 3'd0;
    e.ill = 1'b0;
    if (o.aluop == 2'd1) e.ctl = 3'd1;
    else if (o.aluop == 2'd3) e.ill = 1'b1;
    else if (o.aluop == 2'd2) begin
      if (o.f3 == 3'd0) e.ctl = (o.opr && o.f7) ? 3'd1 : 3'd0;
      else if (o.f3 == 3'd2) e.ctl = 3'd5;
      else if (o.f3 == 3'd6) e.ctl = 3'd3;
      else if (o.f3 == 3'd7) e.ctl = 3'd2;
      else e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input op_t o, input logic vld, input logic rdy, input logic fl);
    @(negedge clk);
    bus.InValid       = vld;
    bus.OutReady      = rdy;
    bus.Flush         = fl;
    bus.RD1           = o.rd1;
    bus.RD2           = o.rd2;
    bus.PCIn          = o.pc;
    bus.ImmIn         = o.imm;
    bus.Rs1           = o.rs1;
    bus.Rs2           = o.rs2;
    bus.RdIn          = o.rdin;
    bus.RegWriteIn    = o.rw;
    bus.ALUSrcA       = o.srca;
    bus.ALUSrcB       = o.srcb;
    bus.ALUOp         = o.aluop;
    bus.Funct3        = o.f3;
    bus.Funct7b5      = o.f7;
    bus.OpR           = o.opr;
    bus.ExMemRegWrite = o.exw;
    bus.ExMemRd       = o.exrd;
    bus.ExMemResult   = o.exres;
    bus.MemWbRegWrite = o.wbw;
    bus.MemWbRd       = o.wbrd;
    bus.MemWbResult   = o.wbres;
    #1;
    n_push = 0;
    // Model-side accept: the queue holds the live op iff the stage is occupied.
    if (vld && !fl && (q.size() == 0 || rdy)) begin
      q.push_back(model(o));
      n_push = 1;
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.rd1   = $urandom;
    o.rd2   = $urandom;
    o.pc    = $urandom;
    o.imm   = $urandom;
    o.rs1   = 5'($urandom_range(0, 3));
    o.rs2   = 5'($urandom_range(0, 3));
    o.rdin  = 5'($urandom);
    o.rw    = 1'($urandom);
    o.srca  = 1'($urandom);
    o.srcb  = 1'($urandom);
    o.aluop = 2'($urandom);
    o.f3    = 3'($urandom);
    o.f7    = 1'($urandom);
    o.opr   = 1'($urandom);
    o.exw   = 1'($urandom);
    o.exrd  = 5'($urandom_range(0, 3));
    o.exres = $urandom;
    o.wbw   = 1'($urandom);
    o.wbrd  = 5'($urandom_range(0, 3));
    o.wbres = $urandom;
    return o;
  endfunction

  // Monitor: just before each rising edge, check handshake and pop on consume.
  initial begin
    exp_t e;
    logic exp_v;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        exp_v = (q.size() > n_push);
        chk("out_valid", 32'(bus.OutValid), 32'(exp_v));
        chk("in_ready", 32'(bus.InReady), 32'(!exp_v || bus.OutReady));
        if (bus.OutValid && bus.OutReady) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 32'(bus.OutValid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("A", bus.A, e.a);
            chk("B", bus.B, e.b);
            chk("ALUControl", 32'(bus.ALUControl), 32'(e.ctl));
            chk("RdOut", 32'(bus.RdOut), 32'(e.rd));
            chk("RegWriteOut", 32'(bus.RegWriteOut), 32'(e.rw));
            chk("PCOut", bus.PCOut, e.pc);
            chk("IllegalOp", 32'(bus.IllegalOp), 32'(e.ill));
          end
        end
        if (bus.Flush) q.delete();
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.OutValid), 32'd0);
    chk({tag, "_A"}, bus.A, 32'd0);
    chk({tag, "_B"}, bus.B, 32'd0);
    chk({tag, "_ctl"}, 32'(bus.ALUControl), 32'd0);
    chk({tag, "_rd"}, 32'(bus.RdOut), 32'd0);
    chk({tag, "_rw"}, 32'(bus.RegWriteOut), 32'd0);
    chk({tag, "_pc"}, bus.PCOut, 32'd0);
    chk({tag, "_ill"}, 32'(bus.IllegalOp), 32'd0);
  endtask

  initial begin
    op_t z, o, o2;
    exp_t e;
    logic rdy, fl;
    z = '0;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    bus.Flush = 1'b0;
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // R-type SUB, no forwarding
    o = z; o.rs1 = 5'd1; o.rd1 = 32'd5; o.rs2 = 5'd2; o.rd2 = 32'd2; o.aluop = 2'b10;
    o.f7 = 1'b1; o.opr = 1'b1; o.rw = 1'b1; o.rdin = 5'd7; o.pc = 32'h100;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    chk("sub_valid", 32'(bus.OutValid), 32'd1);
    chk("sub_A", bus.A, 32'd5);
    chk("sub_B", bus.B, 32'd2);
    chk("sub_ctl", 32'(bus.ALUControl), 32'd1);

    // EX/MEM beats MEM/WB on the same source
    o = z; o.rs1 = 5'd3; o.exw = 1'b1; o.exrd = 5'd3; o.exres = 32'h7FFF_FFFF;
    o.wbw = 1'b1; o.wbrd = 5'd3; o.wbres = 32'd9; o.srcb = 1'b1; o.imm = 32'd1;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fwd_A", bus.A, 32'h7FFF_FFFF);
    chk("fwd_B", bus.B, 32'd1);
    chk("fwd_ctl", 32'(bus.ALUControl), 32'd0);

    // x0 is never forwarded
    o = z; o.exw = 1'b1; o.exres = 32'hDEAD;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    chk("x0_A", bus.A, 32'd0);

    // Decode corners
    o = z; o.aluop = 2'b10; o.f3 = 3'b010;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    chk("slt_ctl", 32'(bus.ALUControl), 32'd5);
    o.f3 = 3'b001;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    chk("ill_ctl", 32'(bus.ALUControl), 32'd0);
    chk("ill_flag", 32'(bus.IllegalOp), 32'd1);
    o = z; o.aluop = 2'b01;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    chk("aluop01_ctl", 32'(bus.ALUControl), 32'd1);

    // Stall three cycles, then back-to-back replace
    o = rand_op();
    o2 = rand_op();
    e = model(o);
    drive(o, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(o2, 1'b1, 1'b0, 1'b0);
      #1;
      chk("stall_in_ready", 32'(bus.InReady), 32'd0);
      chk("stall_A", bus.A, e.a);
      chk("stall_B", bus.B, e.b);
    end
    drive(o2, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    e = model(o2);
    chk("b2b_valid", 32'(bus.OutValid), 32'd1);
    chk("b2b_A", bus.A, e.a);

    // Flush kills held and incoming op
    o = rand_op(); o.rw = 1'b1;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(o, 1'b1, 1'b0, 1'b1);
    drive(z, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_valid", 32'(bus.OutValid), 32'd0);
    chk("flush_rw", 32'(bus.RegWriteOut), 32'd0);

    // Asynchronous reset mid-stall
    o = rand_op(); o.rw = 1'b1; o.pc = 32'h44;
    drive(o, 1'b1, 1'b1, 1'b0);
    drive(z, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    q.delete();
    n_push = 0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      if (fl) rdy = 1'b0;
      drive(rand_op(), 1'($urandom_range(0, 3) != 0), rdy, fl);
    end
    for (int i = 0; i < 3; i++) drive(z, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #4;
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU and drives its A, B and ALUControl inputs.
- Selects operands (rs1 or PC for A; rs2 or immediate for B).
- Applies EX/MEM and MEM/WB forwarding.
- Decodes ALUOp/funct3/funct7 into the 3-bit ALUControl code.
- Holds one issued operation behind a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  decode stage presents an operation.
- InReady  out  1  stage can accept this cycle.
- Flush  in  1  kill held and incoming operation (branch mispredict).
- RD1  in  XLEN  rs1 register-file value.
- RD2  in  XLEN  rs2 register-file value.
- PCIn  in  XLEN  instruction PC.
- ImmIn  in  XLEN  sign-extended immediate.
- Rs1  in  REGW  source index 1.
- Rs2  in  REGW  source index 2.
- RdIn  in  REGW  destination index.
- RegWriteIn  in  1  instruction writes Rd.
- ALUSrcA  in  1  0 selects rs1, 1 selects PC.
- ALUSrcB  in  1  0 selects rs2, 1 selects immediate.
- ALUOp  in  2  00 add, 01 sub, 10 funct-decoded.
- Funct3  in  3  instruction funct3.
- Funct7b5  in  1  instruction bit 30.
- OpR  in  1  1 for R-type (SUB eligible).
- ExMemRegWrite  in  1  EX/MEM forwarding source: write enable.
- ExMemRd  in  REGW  EX/MEM forwarding source: destination index.
- ExMemResult  in  XLEN  EX/MEM forwarding source: result value.
- MemWbRegWrite  in  1  MEM/WB forwarding source: write enable.
- MemWbRd  in  REGW  MEM/WB forwarding source: destination index.
- MemWbResult  in  XLEN  MEM/WB forwarding source: result value.
- OutValid  out  1  A/B/ALUControl valid for the ALU.
- OutReady  in  1  EX consumes this cycle.
- A  out  XLEN  ALU operand A.
- B  out  XLEN  ALU operand B.
- ALUControl  out  3  ALU operation code.
- RdOut  out  REGW  registered destination index.
- RegWriteOut  out  1  registered write enable.
- PCOut  out  XLEN  registered PC.
- IllegalOp  out  1  registered: funct3 unsupported.

Behaviour:
- Reset (rst_n low, asynchronous): OutValid, A, B, ALUControl, RdOut, RegWriteOut, PCOut and IllegalOp all 0.
- InReady = !OutValid || OutReady. Combinational; does not depend on InValid.
- Accept = InValid && InReady && !Flush. On Accept, all outputs are loaded on the next edge, OutValid=1. Latency is 1 cycle from accept to OutValid.
- Consume (OutValid && OutReady) with no Accept: OutValid=0 next edge; data registers hold their values.
- Back-to-back: simultaneous consume and accept replaces the contents and keeps OutValid=1, giving one op per cycle.
- Stall (OutValid && !OutReady): all outputs hold stable. InReady=0.
- Flush: OutValid=0 next edge; the incoming op is dropped; RegWriteOut is cleared. Flush has priority over Accept and over hold.
- Forwarding is evaluated at capture for each source s in {Rs1, Rs2}:
  - If ExMemRegWrite && ExMemRd==s && s!=0, use ExMemResult.
  - Else if MemWbRegWrite && MemWbRd==s && s!=0, use MemWbResult.
  - Else use RD1/RD2.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
  - Forwarded values are not re-sampled while stalled; the hazard unit must hold the producer.
- Operand mux is applied after forwarding:
  - A = ALUSrcA ? PCIn : fwd1.
  - B = ALUSrcB ? ImmIn : fwd2.
- ALUControl decode (codes 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT):
  - ALUOp 00 gives ADD.
  - ALUOp 01 gives SUB.
  - ALUOp 10 with funct3:
    - 000: SUB if OpR && Funct7b5, else ADD.
    - 010: SLT.
    - 110: OR.
    - 111: AND.
    - Any other funct3: ADD with IllegalOp=1.
  - ALUOp 11: ADD with IllegalOp=1.
- Codes 100, 110 and 111 are never emitted.

Decomposition:
- Shared package rv32i_pkg holds:
  - ALU code constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - ALUOp constants.
  - funct3 constants F3_ADD, F3_SLT, F3_OR, F3_AND.
- One combinational sub-module, alu_decoder, maps (ALUOp, Funct3, Funct7b5, OpR) to (ALUControl, IllegalOp). The ALU bench reuses it.
- Forwarding and the pipeline register stay in this block.

Test Plan:
- R-type SUB: Rs1=1 with RD1=5, Rs2=2 with RD2=2, ALUOp=10, Funct3=000, Funct7b5=1, OpR=1, no forwarding -> next cycle OutValid=1, A=5, B=2, ALUControl=001.
- Forwarding priority: Rs1=3, ExMemRd=3 with ExMemResult=0x7FFFFFFF, MemWbRd=3 with MemWbResult=9, ALUSrcB=1, ImmIn=1 -> A=0x7FFFFFFF, B=1, ALUControl=000.
- x0 source: Rs1=0, ExMemRd=0 with ExMemRegWrite=1 and ExMemResult=0xDEAD -> A=RD1 (0); no forwarding occurs.
- Stall then back-to-back: op1 accepted; OutReady=0 for 3 cycles -> outputs stable, InReady=0. OutReady=1 with InValid=1 -> op2 loaded on the next edge with no bubble.
- Flush and reset: Flush=1 while OutValid=1 and InValid=1 -> OutValid=0, RegWriteOut=0 next edge. Asserting rst_n low mid-stall clears all outputs immediately, without waiting for a clock edge.
- Decode corners: ALUOp=10 with Funct3=010 -> ALUControl=101. Funct3=001 -> ALUControl=000, IllegalOp=1. ALUOp=01 -> ALUControl=001.
